// File: rtl/ndma_pkg.sv
// ndma shared types and constants.
// Imported by the OBI read engine and its buffer.
package ndma_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } ndma_rd_state_e;

  localparam int unsigned WordBytes = 4;
  localparam logic [3:0]  ObiBeAll  = 4'hF;

endpackage

// File: rtl/ndma_rsp_buf.sv
// ndma response buffer: small synchronous FIFO.
// Usage count feeds the read-credit check.
module ndma_rsp_buf #(
  parameter  int unsigned Depth = 2,
  parameter  int unsigned Width = 32,
  localparam int unsigned AW    = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned UW    = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [UW-1:0]    usage_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [UW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == AW'(Depth - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == UW'(Depth));
  assign usage_o = cnt_q;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_q];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= nxt(wr_q);
      end
      if (do_pop) begin
        rd_q <= nxt(rd_q);
      end
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + UW'(1);
      end else if (do_pop && !do_push) begin
        cnt_q <= cnt_q - UW'(1);
      end
    end
  end

  // A push into a full buffer without a pop loses data.
  a_no_overflow: assert property (
    @(posedge clk_i) disable iff (rst_i)
    !(push_i && full_o && !pop_i)
  );

endmodule

// File: rtl/ndma_obi_reader.sv
// ndma read engine: issues OBI word reads and
// streams responses out in order under a credit limit.
module ndma_obi_reader
  import ndma_pkg::*;
#(
  parameter  int unsigned MaxOutstanding = 2,
  parameter  int unsigned MaxTxSize      = 256,
  parameter  int unsigned DataWidth      = 32,
  localparam int unsigned LenBits        = $clog2(MaxTxSize + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [31:0]          src_addr_i,
  input  logic [LenBits-1:0]   tx_len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 obi_req_o,
  input  logic                 obi_gnt_i,
  output logic [31:0]          obi_addr_o,
  output logic                 obi_we_o,
  output logic [3:0]           obi_be_o,
  output logic [DataWidth-1:0] obi_wdata_o,
  input  logic                 obi_rvalid_i,
  input  logic [DataWidth-1:0] obi_rdata_i,
  input  logic                 obi_err_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i
);

  localparam int unsigned UW = $clog2(MaxOutstanding + 1);

  ndma_rd_state_e     state_q, state_d;
  logic [31:0]        base_q, base_d;
  logic [LenBits-1:0] len_q, len_d;
  logic [LenBits-1:0] iss_q, iss_d;
  logic [LenBits-1:0] rcv_q, rcv_d;
  logic               err_q, err_d;
  logic               hold_q, hold_d;

  logic [UW-1:0]      usage;
  logic               buf_full;
  logic               buf_empty;
  logic               pop;
  logic [LenBits:0]   inflight;
  logic               credit;
  logic               req;

  // Granted-but-unanswered reads plus buffered words.
  assign inflight = {1'b0, iss_q - rcv_q}
                  + (LenBits + 1)'(usage);
  assign credit   = !buf_full &&
    (inflight < (LenBits + 1)'(MaxOutstanding));

  // Once raised, a request is held until granted.
  assign req = (state_q == ISSUE) &&
               (iss_q != len_q) &&
               (credit || hold_q);
  assign hold_d = req && !obi_gnt_i;

  assign obi_req_o   = req;
  assign obi_addr_o  = base_q + 32'(iss_q) * 32'(WordBytes);
  assign obi_we_o    = 1'b0;
  assign obi_be_o    = ObiBeAll;
  assign obi_wdata_o = '0;

  assign busy_o  = (state_q != IDLE);
  assign done_o  = (state_q == DONE);
  assign err_o   = err_q;
  assign valid_o = !buf_empty;
  assign pop     = valid_o && ready_i;

  ndma_rsp_buf #(
    .Depth (MaxOutstanding),
    .Width (DataWidth)
  ) u_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (obi_rvalid_i),
    .pop_i   (pop),
    .data_i  (obi_rdata_i),
    .data_o  (data_o),
    .full_o  (buf_full),
    .empty_o (buf_empty),
    .usage_o (usage)
  );

  // Next-state and counter updates.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    iss_d   = iss_q;
    rcv_d   = rcv_q;
    err_d   = err_q;
    if (obi_rvalid_i) begin
      rcv_d = rcv_q + LenBits'(1);
      if (obi_err_i) begin
        err_d = 1'b1;
      end
    end
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          base_d  = {src_addr_i[31:2], 2'b00};
          len_d   = tx_len_i;
          iss_d   = '0;
          rcv_d   = '0;
          err_d   = 1'b0;
          state_d = (tx_len_i == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (req && obi_gnt_i) begin
          iss_d = iss_q + LenBits'(1);
          if ((iss_q + LenBits'(1)) == len_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if ((rcv_q == len_q) && buf_empty) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and transfer registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      base_q  <= '0;
      len_q   <= '0;
      iss_q   <= '0;
      rcv_q   <= '0;
      err_q   <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      iss_q   <= iss_d;
      rcv_q   <= rcv_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: tb/tb_ndma_obi_reader.sv
// Bench for ndma_obi_reader: OBI memory model,
// stream sink and reference checks per cycle.
module tb_ndma_obi_reader;

  localparam int MAXO = 2;
  localparam int LB   = 9;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic          start_i = 1'b0;
  logic [31:0]   src_addr_i = '0;
  logic [LB-1:0] tx_len_i = '0;
  logic          busy_o, done_o, err_o;
  logic          obi_req_o;
  logic          obi_gnt_i = 1'b0;
  logic [31:0]   obi_addr_o;
  logic          obi_we_o;
  logic [3:0]    obi_be_o;
  logic [31:0]   obi_wdata_o;
  logic          obi_rvalid_i = 1'b0;
  logic [31:0]   obi_rdata_i = '0;
  logic          obi_err_i = 1'b0;
  logic [31:0]   data_o;
  logic          valid_o;
  logic          ready_i = 1'b0;

  ndma_obi_reader dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .src_addr_i   (src_addr_i),
    .tx_len_i     (tx_len_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .obi_req_o    (obi_req_o),
    .obi_gnt_i    (obi_gnt_i),
    .obi_addr_o   (obi_addr_o),
    .obi_we_o     (obi_we_o),
    .obi_be_o     (obi_be_o),
    .obi_wdata_o  (obi_wdata_o),
    .obi_rvalid_i (obi_rvalid_i),
    .obi_rdata_i  (obi_rdata_i),
    .obi_err_i    (obi_err_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          fails = 0;
  logic [31:0] addrs[$];
  logic [31:0] got[$];
  logic [31:0] pend[$];
  logic [31:0] seed;
  logic [31:0] cur_src;
  logic [LB-1:0] cur_len;
  int          done_cnt, err_at, rsp_idx, start_pend;
  bit          prev_done, prev_rv, err_ref;
  bit          gnt_en, gnt_rand, rdy_en, rdy_rand, rsp_rand;

  task automatic chk(input string tag,
                     input logic [31:0] got_v,
                     input logic [31:0] exp_v);
    checks++;
    assert (got_v === exp_v) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got_v, exp_v);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ seed;
  endfunction

  // One cycle: check outputs, then drive the next inputs.
  task automatic tick();
    int infl;
    @(negedge clk);
    if (prev_done) begin
      chk("busy_after_done", busy_o, 0);
      chk("done_width", done_o, 0);
    end
    if (prev_rv) chk("valid_latency", valid_o, 1);
    chk("err", err_o, err_ref);
    infl = addrs.size() - got.size();
    chk("bound", infl <= MAXO, 1);
    if (obi_req_o) chk("credit", infl < MAXO, 1);
    prev_done = done_o;
    if (done_o) done_cnt++;
    obi_rvalid_i = 1'b0;
    obi_err_i    = 1'b0;
    obi_rdata_i  = '0;
    if (pend.size() > 0 && (!rsp_rand || $urandom_range(0, 1) == 1)) begin
      logic [31:0] a;
      a = pend.pop_front();
      obi_rvalid_i = 1'b1;
      obi_rdata_i  = memf(a);
      if (rsp_idx == err_at) begin
        obi_err_i = 1'b1;
        err_ref   = 1'b1;
      end
      rsp_idx++;
    end
    prev_rv = obi_rvalid_i;
    obi_gnt_i = gnt_en && (!gnt_rand || $urandom_range(0, 2) != 0);
    if (obi_req_o && obi_gnt_i) begin
      addrs.push_back(obi_addr_o);
      pend.push_back(obi_addr_o);
    end
    ready_i = rdy_en && (!rdy_rand || $urandom_range(0, 2) != 0);
    if (valid_o && ready_i) got.push_back(data_o);
    start_i = 1'b0;
    if (start_pend != 0) begin
      start_i    = 1'b1;
      src_addr_i = cur_src;
      tx_len_i   = cur_len;
      if (start_pend == 1) err_ref = 1'b0;
      start_pend = 0;
    end
  endtask

  task automatic start_xfer(input logic [31:0] src,
                            input int len, input int ea);
    addrs.delete();
    got.delete();
    pend.delete();
    done_cnt   = 0;
    rsp_idx    = 0;
    err_at     = ea;
    cur_src    = src;
    cur_len    = LB'(len);
    start_pend = 1;
    tick();
  endtask

  task automatic finish_xfer(input logic [31:0] base,
                             input int len, input bit err_exp);
    int n = 0;
    while (done_cnt == 0 && n < 3000) begin
      tick();
      n++;
    end
    chk("timeout", done_cnt != 0, 1);
    tick();
    chk("done_count", done_cnt, 1);
    chk("err_end", err_o, err_exp);
    chk("n_addr", addrs.size(), len);
    chk("n_data", got.size(), len);
    for (int i = 0; i < len; i++) begin
      if (i < addrs.size()) chk("addr", addrs[i], base + 32'(i) * 4);
      if (i < got.size()) chk("data", got[i], memf(base + 32'(i) * 4));
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_err"}, err_o, 0);
    chk({tag, "_req"}, obi_req_o, 0);
    chk({tag, "_addr"}, obi_addr_o, 0);
    chk({tag, "_valid"}, valid_o, 0);
    chk({tag, "_data"}, data_o, 0);
  endtask

  initial begin
    int n;
    logic [31:0] a0;
    seed = $urandom;
    gnt_en = 1; gnt_rand = 0;
    rdy_en = 1; rdy_rand = 0;
    rsp_rand = 0;
    err_at = -1;
    #1 rst_i = 1'b1;
    #2 chk_reset_outs("rst");
    chk("we", obi_we_o, 0);
    chk("be", obi_be_o, 32'hF);
    chk("wdata", obi_wdata_o, 0);
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;

    start_xfer(32'h1000, 4, -1);
    finish_xfer(32'h1000, 4, 0);

    rdy_en = 0;
    start_xfer(32'h3000, 8, -1);
    repeat (20) tick();
    chk("bp_grants", addrs.size(), 2);
    chk("bp_req", obi_req_o, 0);
    rdy_en = 1;
    finish_xfer(32'h3000, 8, 0);

    gnt_en = 0;
    start_xfer(32'h4000, 3, -1);
    n = 0;
    while (!obi_req_o && n < 10) begin
      tick();
      n++;
    end
    chk("stall_req_seen", obi_req_o, 1);
    a0 = obi_addr_o;
    chk("stall_addr0", a0, 32'h4000);
    repeat (5) begin
      tick();
      chk("stall_req", obi_req_o, 1);
      chk("stall_addr", obi_addr_o, a0);
    end
    chk("stall_grants", addrs.size(), 0);
    gnt_en = 1;
    finish_xfer(32'h4000, 3, 0);

    start_xfer(32'h5000, 0, -1);
    tick();
    chk("zl_done", done_o, 1);
    finish_xfer(32'h5000, 0, 0);

    start_xfer(32'h2003, 1, -1);
    finish_xfer(32'h2003 & ~32'h3, 1, 0);

    start_xfer(32'hFFFF_FFF8, 4, 2);
    finish_xfer(32'hFFFF_FFF8, 4, 1);

    start_xfer(32'h6000, 5, -1);
    tick();
    cur_src = 32'h9000;
    cur_len = LB'(7);
    start_pend = 2;
    finish_xfer(32'h6000, 5, 0);
    repeat (3) tick();
    chk("ign_busy", busy_o, 0);
    chk("ign_addrs", addrs.size(), 5);

    start_xfer(32'h7000, 16, -1);
    n = 0;
    while (addrs.size() < 16 && n < 200) begin
      tick();
      n++;
    end
    chk("mid_issued", addrs.size(), 16);
    tick();
    #2 rst_i = 1'b1;
    #1 chk_reset_outs("mid");
    obi_rvalid_i = 1'b0;
    obi_err_i = 1'b0;
    pend.delete();
    addrs.delete();
    got.delete();
    prev_rv = 0;
    prev_done = 0;
    err_ref = 0;
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    start_xfer(32'h8000, 2, -1);
    finish_xfer(32'h8000, 2, 0);

    gnt_rand = 1;
    rdy_rand = 1;
    rsp_rand = 1;
    for (int k = 0; k < 5; k++) begin
      logic [31:0] s;
      int l, ea;
      s  = $urandom;
      l  = $urandom_range(1, 24);
      ea = ($urandom_range(0, 1) == 1) ? $urandom_range(0, l - 1) : -1;
      start_xfer(s, l, ea);
      finish_xfer(s & ~32'h3, l, ea >= 0);
    end
    start_xfer(32'h0001_0000, 256, -1);
    finish_xfer(32'h0001_0000, 256, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
